clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels, legal 1..16.
REQ-002 Parameter WIDTH, default 16: width of each channel's divide ratio and counter, legal 2..32.
REQ-003 Parameter RESET_DIV, default 2: divide ratio loaded into every channel at reset, SHALL be nonzero and fit in WIDTH.
REQ-004 clk_in  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  CHANNELS  per-channel run enable, level-sensitive.
REQ-007 div_load  input  1  one-cycle strobe writing div_value to channel div_sel.
REQ-008 div_sel  input  clog2(CHANNELS), minimum 1  target channel for div_load.
REQ-009 div_value  input  WIDTH  new divide ratio N.
REQ-010 tick  output  CHANNELS  one-cycle pulse per period, usable as a clock enable.
REQ-011 clk_out  output  CHANNELS  divided square wave, registered.
REQ-012 running  output  CHANNELS  channel is counting.

Function
REQ-013 Each channel SHALL hold an active ratio N and a shadow ratio S, plus a down-counter C of WIDTH bits.
REQ-014 Each channel SHALL have two states: IDLE (C = 0, all outputs 0) and RUN.
- IDLE to RUN when enable=1 and S != 0: N <= S, C <= S-1.
- RUN to IDLE when enable=0, taking effect on the next edge.
REQ-015 In RUN, C SHALL decrement each cycle. At C = 0, C SHALL reload to N-1, where N is first updated from S.
REQ-016 tick SHALL assert, registered, in the cycle after the counter reaches C = 0. Its period SHALL be exactly N clk_in cycles, and the first tick SHALL occur N cycles after the RUN entry edge.
REQ-017 clk_out SHALL be 1 while C >= N/2 (integer division) and 0 otherwise, with one cycle of registered latency. This gives ceil(N/2) cycles high and floor(N/2) cycles low.
REQ-018 When N = 1, tick and clk_out SHALL be constant 1 while in RUN.
REQ-019 A div_load SHALL write S of channel div_sel on the same edge. A channel in RUN SHALL adopt the new ratio only at its next terminal count, so no period is ever truncated. A channel in IDLE SHALL adopt it on its next RUN entry.
REQ-020 A div_load with div_value = 0 SHALL be accepted into S. At the next terminal count the channel SHALL enter IDLE, and it SHALL stay in IDLE until a nonzero S is loaded and enable is high.
REQ-021 A div_load with div_sel >= CHANNELS SHALL be ignored.
REQ-022 When div_load and a terminal count coincide on the same channel, the old S SHALL be adopted this period and the new S at the following terminal count.
REQ-023 Channels SHALL be fully independent. Loading or enabling one channel SHALL NOT perturb the phase of any other.
REQ-024 Deasserting enable mid-period SHALL abandon the period with no partial tick. Outputs SHALL be 0 from the following cycle.

Reset
REQ-025 While rst_n = 0, every channel SHALL be IDLE, with N = S = RESET_DIV and C = 0.
REQ-026 While rst_n = 0, tick, clk_out and running SHALL all be 0, asynchronously.
REQ-027 Reset assertion mid-period SHALL discard all state. The first edge after rst_n deasserts SHALL be treated as an ordinary cycle.

Structure
REQ-028 A shared package SHALL hold the channel-state encoding (IDLE, RUN) and the default constants for CHANNELS, WIDTH and RESET_DIV.
REQ-029 Per-channel logic SHALL live in one sub-module, divider_channel, instantiated CHANNELS times by a generate loop. clock_divider SHALL contain only load decoding and port fan-out.

Verification
REQ-030 Basic run: reset, enable[0]=1 with RESET_DIV = 2 -> tick[0] every 2nd cycle, first tick 2 cycles after enable; clk_out[0] 1,0,1,0.
REQ-031 Odd ratio: load N = 5 on channel 1, enable -> tick period 5; clk_out[1] 3 cycles high, 2 low; running[1] = 1.
REQ-032 Glitch-free reload: channel 2 running at N = 8, load 3 mid-period -> the current 8-cycle period completes, then periods of 3; channels 0 and 1 show no phase change.
REQ-033 Zero and unity ratios: load 1 -> tick and clk_out held at 1. Then load 0 -> channel IDLE after the current period, all outputs 0, running = 0.
REQ-034 Edge cases: div_sel = CHANNELS during load -> no state change in any channel. Enable dropped at C = 2 -> no tick, outputs 0 next cycle.
REQ-035 Asynchronous reset: assert rst_n low mid-period between clock edges -> outputs 0 immediately. After release, all channels use ratio RESET_DIV.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Shared definitions for the multi-channel clock divider:
//   channel state encoding, default parameter values and the
//   helper that sizes the channel-select bus.
package clock_divider_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_RESET_DIV = 2;

  // Width of the channel-select bus; never narrower than one bit so a
  // single-channel build still has a real port.
  function automatic int sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// divider_channel
//   One independent divider channel: active ratio N, shadow ratio S and a
//   down-counter C. Produces a one-cycle tick per period and a registered
//   square wave (ceil(N/2) high, floor(N/2) low).
//
// Ports
//   clk_in     : clock
//   rst_n      : async active-low reset
//   enable     : level-sensitive run enable
//   load       : strobe writing load_value into the shadow ratio S
//   load_value : new divide ratio
//   tick       : one-cycle pulse per period
//   clk_out    : divided square wave
//   running    : channel is in RUN
//
// State table
//   state   | meaning
//   CH_IDLE | C = 0, outputs 0; waits for enable with S != 0
//   CH_RUN  | C counts down N-1..0; reloads from S at terminal count
module divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick,
  output logic             clk_out,
  output logic             running
);

  localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  ch_state_t        state, state_nxt;
  logic [WIDTH-1:0] n_act, n_nxt;
  logic [WIDTH-1:0] s_shd;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             tick_q, tick_nxt;
  logic             clk_q, clk_nxt;
  logic             term_cnt;

  assign term_cnt = (cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CH_IDLE;
      n_act  <= RESET_RATIO;
      s_shd  <= RESET_RATIO;
      cnt    <= '0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      n_act  <= n_nxt;
      cnt    <= cnt_nxt;
      tick_q <= tick_nxt;
      clk_q  <= clk_nxt;
      // S is read by the next-state logic before this write lands, so a
      // load coinciding with a terminal count is adopted one period later.
      if (load) begin
        s_shd <= load_value;
      end
    end
  end

  // Outputs are only driven when the channel stays in RUN across this edge,
  // so an enable drop or a zero-ratio stop yields all-zero outputs at once.
  always_comb begin
    state_nxt = state;
    n_nxt     = n_act;
    cnt_nxt   = cnt;
    tick_nxt  = 1'b0;
    clk_nxt   = 1'b0;
    case (state)
      CH_IDLE: begin
        if (enable && (s_shd != '0)) begin
          state_nxt = CH_RUN;
          n_nxt     = s_shd;
          cnt_nxt   = s_shd - ONE;
        end
      end
      CH_RUN: begin
        if (!enable) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end else if (term_cnt && (s_shd == '0)) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end else begin
          tick_nxt = term_cnt;
          clk_nxt  = (cnt >= (n_act >> 1));
          if (term_cnt) begin
            n_nxt   = s_shd;
            cnt_nxt = s_shd - ONE;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      default: begin
        state_nxt = CH_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign running = (state == CH_RUN);

endmodule

// File: rtl/clock_divider.sv
// clock_divider
//   CHANNELS independent programmable clock dividers sharing one clock.
//   This level only decodes the ratio-load strobe and fans ports out to
//   the per-channel instances.
//
// Ports
//   clk_in    : single clock for all logic
//   rst_n     : async active-low reset
//   enable    : per-channel run enable
//   div_load  : one-cycle strobe writing div_value to channel div_sel
//   div_sel   : target channel for div_load
//   div_value : new divide ratio
//   tick      : per-channel one-cycle pulse per period
//   clk_out   : per-channel divided square wave
//   running   : per-channel counting status
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          div_load,
  input  logic [sel_w(CHANNELS)-1:0]    div_sel,
  input  logic [WIDTH-1:0]              div_value,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           clk_out,
  output logic [CHANNELS-1:0]           running
);

  localparam int SEL_W = sel_w(CHANNELS);

  logic [CHANNELS-1:0] load_hit;

  // Selects at or beyond CHANNELS match no instance and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load_hit[i] = div_load && (div_sel == SEL_W'(i));

    divider_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .enable     (enable[i]),
      .load       (load_hit[i]),
      .load_value (div_value),
      .tick       (tick[i]),
      .clk_out    (clk_out[i]),
      .running    (running[i])
    );
  end

endmodule

// File: tb/tb_clock_divider.sv
module tb_clock_divider;

  localparam int CH    = 3;
  localparam int W     = 8;
  localparam int RDIV  = 2;
  localparam int SEL_W = 2;

  logic            clk_in = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   enable = '0;
  logic            div_load = 1'b0;
  logic [SEL_W-1:0] div_sel = '0;
  logic [W-1:0]    div_value = '0;
  logic [CH-1:0]   tick, clk_out, running;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  clock_divider #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .RESET_DIV (RDIV)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .div_load  (div_load),
    .div_sel   (div_sel),
    .div_value (div_value),
    .tick      (tick),
    .clk_out   (clk_out),
    .running   (running)
  );

  // Behavioural model: each channel tracks whether it runs, its ratio, its
  // shadow ratio and how many cycles of the current period have elapsed.
  bit            m_run [CH] = '{default: 1'b0};
  int            m_n   [CH] = '{default: RDIV};
  int            m_s   [CH] = '{default: RDIV};
  int            m_pos [CH] = '{default: 0};
  logic [CH-1:0] e_tick = '0;
  logic [CH-1:0] e_clk  = '0;
  logic [CH-1:0] e_run  = '0;

  always @(posedge clk_in or negedge rst_n) begin : model
    int p;
    int old_s;
    bit ld;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 1'b0;
        m_n[i]   = RDIV;
        m_s[i]   = RDIV;
        m_pos[i] = 0;
      end
      e_tick = '0;
      e_clk  = '0;
      e_run  = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        ld        = div_load && (int'(div_sel) == i);
        old_s     = m_s[i];
        e_tick[i] = 1'b0;
        e_clk[i]  = 1'b0;
        if (!m_run[i]) begin
          if (enable[i] && old_s != 0) begin
            m_run[i] = 1'b1;
            m_n[i]   = old_s;
            m_pos[i] = 0;
          end
        end else if (!enable[i]) begin
          m_run[i] = 1'b0;
        end else begin
          p = m_pos[i] + 1;
          if (p == m_n[i]) begin
            if (old_s == 0) begin
              m_run[i] = 1'b0;
            end else begin
              e_tick[i] = 1'b1;
              e_clk[i]  = (p <= (m_n[i] + 1) / 2);
              m_n[i]    = old_s;
              m_pos[i]  = 0;
            end
          end else begin
            e_clk[i] = (p <= (m_n[i] + 1) / 2);
            m_pos[i] = p;
          end
        end
        e_run[i] = m_run[i];
        if (ld) m_s[i] = int'(div_value);
      end
    end
  end

  always @(negedge clk_in) begin
    checks++;
    if (tick !== e_tick) begin
      errors++;
      $display("FAIL model_tick t=%0t: got %b expected %b", $time, tick, e_tick);
    end
    checks++;
    if (clk_out !== e_clk) begin
      errors++;
      $display("FAIL model_clk_out t=%0t: got %b expected %b", $time, clk_out, e_clk);
    end
    checks++;
    if (running !== e_run) begin
      errors++;
      $display("FAIL model_running t=%0t: got %b expected %b", $time, running, e_run);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic load(input int sel, input int val);
    div_load  = 1'b1;
    div_sel   = SEL_W'(sel);
    div_value = W'(val);
    cyc();
    div_load  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      cyc();
      if (tick[ch]) found = 1'b1;
    end
    chk("wait_tick", 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [0:4] c1;
    logic [0:4] t1;
    logic [0:9] c5;
    logic [0:9] t5;
    c1 = 5'b01010;
    t1 = 5'b00101;
    c5 = 10'b1110011100;
    t5 = 10'b0000100001;

    // Reset state
    cyc();
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic run at the reset ratio of 2
    enable[0] = 1'b1;
    cyc();
    chk("basic_running", 32'(running[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("basic_clk", 32'(clk_out[0]), 32'(c1[k]));
      chk("basic_tick", 32'(tick[0]), 32'(t1[k]));
      cyc();
    end

    // Odd ratio 5 on channel 1
    load(1, 5);
    enable[1] = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("odd_clk", 32'(clk_out[1]), 32'(c5[k]));
      chk("odd_tick", 32'(tick[1]), 32'(t5[k]));
      chk("odd_running", 32'(running[1]), 32'd1);
    end

    // Glitch-free reload: 8 then 3 loaded during the first period
    load(2, 8);
    enable[2] = 1'b1;
    cyc();
    for (int idx = 1; idx <= 17; idx++) begin
      if (idx == 3) begin
        div_load  = 1'b1;
        div_sel   = 2'd2;
        div_value = 8'd3;
      end else begin
        div_load  = 1'b0;
      end
      cyc();
      chk("reload_tick", 32'(tick[2]),
          32'(idx == 8 || idx == 11 || idx == 14 || idx == 17));
      if (idx <= 8) chk("reload_clk", 32'(clk_out[2]), 32'(idx <= 4));
    end
    div_load = 1'b0;

    // Unity ratio holds tick and clk_out high
    load(0, 1);
    repeat (3) cyc();
    for (int k = 0; k < 4; k++) begin
      chk("unity_tick", 32'(tick[0]), 32'd1);
      chk("unity_clk", 32'(clk_out[0]), 32'd1);
      cyc();
    end

    // Zero ratio stops the channel after the current period
    load(0, 0);
    cyc();
    chk("zero_running", 32'(running[0]), 32'd0);
    chk("zero_tick", 32'(tick[0]), 32'd0);
    chk("zero_clk", 32'(clk_out[0]), 32'd0);
    repeat (3) cyc();
    chk("zero_stays_idle", 32'(running[0]), 32'd0);

    // Out-of-range select touches nothing
    load(3, 7);
    repeat (4) cyc();
    chk("badsel_ch0_idle", 32'(running[0]), 32'd0);

    // Enable dropped on channel 1 while its counter is at 2
    wait_tick(1, 12);
    cyc();
    cyc();
    enable[1] = 1'b0;
    cyc();
    chk("drop_tick", 32'(tick[1]), 32'd0);
    chk("drop_clk", 32'(clk_out[1]), 32'd0);
    chk("drop_running", 32'(running[1]), 32'd0);
    repeat (5) begin
      cyc();
      chk("drop_stays_low", 32'(tick[1] | clk_out[1]), 32'd0);
    end

    // Asynchronous reset between edges, then restart at the reset ratio
    enable = 3'b111;
    load(1, 5);
    repeat (4) cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_clk_out", 32'(clk_out), 32'd0);
    chk("async_running", 32'(running), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_reset_running", 32'(running), 32'h7);
    chk("post_reset_clk0", 32'(clk_out), 32'h0);
    cyc();
    chk("post_reset_clk1", 32'(clk_out), 32'h7);
    chk("post_reset_tick1", 32'(tick), 32'h0);
    cyc();
    chk("post_reset_clk2", 32'(clk_out), 32'h0);
    chk("post_reset_tick2", 32'(tick), 32'h7);
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
